// File: rtl/sa_matmul_sched.sv
// Pass scheduler for an N x N systolic MAC array: clear, skewed feed, flush, row drain.
// Optional abort input is compiled in when SA_SCHED_ABORT_EN is defined.
module sa_matmul_sched #(
    parameter int N       = 4,
    parameter int K_W     = 8,
    parameter int MAC_LAT = 1,
    parameter int ROW_W   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [K_W-1:0]   k_len,
`ifdef SA_SCHED_ABORT_EN
    input  logic             abort,
`endif
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             acc_clr,
    output logic             rd_en,
    output logic [K_W-1:0]   rd_addr,
    output logic [N-1:0]     row_valid,
    output logic [N-1:0]     col_valid,
    output logic             out_valid,
    output logic [ROW_W-1:0] out_row
);

    localparam int TW = K_W + ROW_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    t_q, t_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [ROW_W-1:0] row_q, row_d;

    logic [TW-1:0]    k_ext;
    logic [TW-1:0]    feed_last;
    logic [TW-1:0]    flush_last;

    // Feed length is k + 2N - 2, so the last feed tick is k + 2N - 3 (N >= 2 keeps this positive).
    assign k_ext      = TW'(k_q);
    assign feed_last  = k_ext + TW'(2 * N - 3);
    assign flush_last = TW'(MAC_LAT - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            k_q     <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            k_q     <= k_d;
            row_q   <= row_d;
        end
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        k_d     = k_q;
        row_d   = row_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    k_d     = k_len;
                    t_d     = '0;
                    row_d   = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                t_d     = '0;
                state_d = (k_q != '0) ? S_FEED : S_FLUSH;
            end
            S_FEED: begin
                if (t_q == feed_last) begin
                    t_d     = '0;
                    state_d = S_FLUSH;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            // The same counter times the flush so the array pipeline empties before draining.
            S_FLUSH: begin
                if (t_q == flush_last) begin
                    t_d     = '0;
                    row_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    if (row_q == ROW_W'(N - 1)) begin
                        row_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef SA_SCHED_ABORT_EN
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            t_d     = '0;
            k_d     = '0;
            row_d   = '0;
        end
`endif
    end

    // Outputs decode purely from registered state, so IDLE (and therefore reset) forces them all low.
    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        acc_clr   = (state_q == S_CLEAR);
        rd_en     = 1'b0;
        rd_addr   = '0;
        row_valid = '0;
        col_valid = '0;
        out_valid = 1'b0;
        out_row   = '0;
        if (state_q == S_FEED) begin
            rd_en = (t_q < k_ext);
            if (rd_en) begin
                rd_addr = t_q[K_W-1:0];
            end
            for (int i = 0; i < N; i++) begin
                row_valid[i] = (t_q >= TW'(i)) && (t_q < (TW'(i) + k_ext));
            end
            col_valid = row_valid;
        end
        if (state_q == S_DRAIN) begin
            out_valid = 1'b1;
            out_row   = row_q;
        end
    end

endmodule

// File: tb/tb_sa_matmul_sched.sv
// Self-checking bench for sa_matmul_sched: random passes checked cycle by cycle
// against a timeline model derived from the pass arithmetic (clear, feed, flush, drain, done).
module tb_sa_matmul_sched;

    localparam int N       = 4;
    localparam int K_W     = 8;
    localparam int MAC_LAT = 1;
    localparam int ROW_W   = 2;
    localparam int OW      = 4 + K_W + 2 * N + 1 + ROW_W;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [K_W-1:0]   k_len = '0;
    logic             out_ready = 1'b0;
`ifdef SA_SCHED_ABORT_EN
    logic             abort = 1'b0;
`endif
    logic             busy, done, acc_clr, rd_en, out_valid;
    logic [K_W-1:0]   rd_addr;
    logic [N-1:0]     row_valid, col_valid;
    logic [ROW_W-1:0] out_row;

    int checkCount = 0;
    int failCount  = 0;

    sa_matmul_sched #(.N(N), .K_W(K_W), .MAC_LAT(MAC_LAT), .ROW_W(ROW_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .k_len     (k_len),
`ifdef SA_SCHED_ABORT_EN
        .abort     (abort),
`endif
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .acc_clr   (acc_clr),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .row_valid (row_valid),
        .col_valid (col_valid),
        .out_valid (out_valid),
        .out_row   (out_row)
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] observed();
        return {busy, done, acc_clr, rd_en, rd_addr, row_valid, col_valid, out_valid, out_row};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One pass: accept start with k, then each cycle compare every output with the timeline model.
    // Special cycles (0 = unused): two ignored restarts, a mid-pass reset, an abort; stallRow gets 5 stall cycles.
    task automatic applyStimulus(input int k, input int stallPct, input int stallRow,
                                 input int restartA, input int restartB,
                                 input int resetAt, input int abortAt);
        int f, drainStart, rows, c, stalls, rowStalls, t;
        bit finished, eRd, eOv, eDone, eClr;
        logic [K_W-1:0]   eAddr;
        logic [N-1:0]     eRv;
        logic [ROW_W-1:0] eRow;
        logic [OW-1:0]    expVec;
        f          = (k == 0) ? 0 : k + 2 * N - 2;
        drainStart = 2 + f + MAC_LAT;
        @(negedge clk);
        start     = 1'b1;
        k_len     = K_W'(k);
        out_ready = 1'b1;
        @(posedge clk);
        c = 1; rows = 0; stalls = 0; rowStalls = 0; finished = 0;
        while (!finished && c < 3000) begin
            @(negedge clk);
            start = 1'b0;
            eClr = 0; eRd = 0; eAddr = '0; eRv = '0; eOv = 0; eRow = '0; eDone = 0;
            if (c == 1) begin
                eClr = 1;
            end else if (c < 2 + f) begin
                t     = c - 2;
                eRd   = (t < k);
                eAddr = eRd ? K_W'(t) : '0;
                for (int i = 0; i < N; i++) eRv[i] = (t >= i) && (t < i + k);
            end else if (c < drainStart) begin
                eClr = 0;
            end else if (rows < N) begin
                eOv  = 1;
                eRow = ROW_W'(rows);
            end else begin
                eDone = 1;
            end
            expVec = {1'b1, eDone, eClr, eRd, eAddr, eRv, eRv, eOv, eRow};
            checkOutput($sformatf("k=%0d cycle %0d outputs", k, c), 64'(observed()), 64'(expVec));
            if (eDone) begin
                checkOutput($sformatf("k=%0d done latency", k), 64'(c), 64'(1 + f + MAC_LAT + N + 1 + stalls));
                finished = 1;
            end
            if (c == resetAt) begin
                rst_n = 1'b0;
                #1;
                checkOutput("async reset outputs", 64'(observed()), 64'(0));
                @(negedge clk);
                checkOutput("held in reset", 64'(observed()), 64'(0));
                rst_n = 1'b1;
                return;
            end
`ifdef SA_SCHED_ABORT_EN
            if (c == abortAt) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                checkOutput("abort to idle", 64'(observed()), 64'(0));
                @(negedge clk);
                checkOutput("no done after abort", 64'(observed()), 64'(0));
                return;
            end
`endif
            if (c == restartA || c == restartB) begin
                start = 1'b1;
                k_len = K_W'(7);
            end
            if (eOv && rows == stallRow && rowStalls < 5) begin
                out_ready = 1'b0;
                rowStalls++;
            end else begin
                out_ready = ($urandom_range(0, 99) >= stallPct);
            end
            if (eOv && !out_ready) stalls++;
            @(posedge clk);
            if (eOv && out_ready) rows++;
            c++;
        end
        if (!finished) checkOutput("pass timeout", 64'(0), 64'(1));
        @(negedge clk);
        start = 1'b0;
        checkOutput("idle after done", 64'(observed()), 64'(0));
    endtask

    initial begin
        int kr, sp;
        #12;
        checkOutput("reset state", 64'(observed()), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle after reset", 64'(observed()), 64'(0));

        $display("[TB] baseline pass k=3");
        applyStimulus(3, 0, -1, 0, 0, 0, 0);
        $display("[TB] backpressure at row 2");
        applyStimulus(3, 0, 2, 0, 0, 0, 0);
        $display("[TB] empty pass k=0");
        applyStimulus(0, 0, -1, 0, 0, 0, 0);
        $display("[TB] ignored restarts in FEED and DRAIN");
        applyStimulus(3, 0, -1, 5, 13, 0, 0);
        $display("[TB] reset mid-FEED then k=2 pass");
        applyStimulus(3, 0, -1, 0, 0, 6, 0);
        applyStimulus(2, 0, -1, 0, 0, 0, 0);
`ifdef SA_SCHED_ABORT_EN
        $display("[TB] abort during DRAIN at row 1");
        applyStimulus(3, 0, -1, 0, 0, 0, 13);
        applyStimulus(1, 0, -1, 0, 0, 0, 0);
`endif
        $display("[TB] randomized passes");
        for (int p = 0; p < 6; p++) begin
            kr = $urandom_range(0, 12);
            sp = $urandom_range(0, 50);
            applyStimulus(kr, sp, -1, 0, 0, 0, 0);
        end
        $display("[TB] maximum k_len");
        applyStimulus(255, 20, -1, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
        $finish;
    end

endmodule
